// File: rtl/vx_reduce_arbiter.sv
// Shares one reduce unit between NUM_REQS issue ports, granting whole sop..eop sequences.
// A grant is released only once the eop packet is accepted and the unit has committed its eop.
module vx_reduce_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64,
  parameter int TIMEOUT  = 0,
  localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]       req_sop,
  input  logic [NUM_REQS-1:0]       req_eop,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_sel,
  input  logic                      commit_fire,
  input  logic                      commit_eop,
  output logic                      busy,
  output logic                      stall_err
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t          state;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] winner;
  logic            eop_sent;
  logic            eop_done;
  logic [WDW-1:0]  wdog;
  logic            out_fire;
  logic            eop_fire;
  logic            sent_now;
  logic            done_now;
  logic            release_now;

  // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (req_valid[(int'(rr_ptr) + i) % NUM_REQS]) begin
        winner = SELW'((int'(rr_ptr) + i) % NUM_REQS);
      end else begin
        winner = winner;
      end
    end
  end

  // Forward the granted port; after its eop is accepted nothing more passes until release.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    req_ready = '0;
    if (state == STREAM) begin
      out_data           = req_data[int'(out_sel)*DATAW +: DATAW];
      out_sop            = req_sop[out_sel];
      out_eop            = req_eop[out_sel];
      out_valid          = req_valid[out_sel] & ~eop_sent;
      req_ready[out_sel] = out_ready & ~eop_sent;
    end else begin
      req_ready = '0;
    end
  end

  assign out_fire    = out_valid & out_ready;
  assign eop_fire    = out_fire & out_eop;
  assign sent_now    = eop_sent | eop_fire;
  assign done_now    = eop_done | (commit_fire & commit_eop);
  assign release_now = (state == STREAM) & sent_now & done_now;
  assign busy        = (state == STREAM);

  // Grant state machine with the two release flags and the round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      out_sel  <= '0;
      eop_sent <= 1'b0;
      eop_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          eop_sent <= 1'b0;
          eop_done <= 1'b0;
          if (|req_valid) begin
            out_sel <= winner;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (release_now) begin
            state    <= IDLE;
            eop_sent <= 1'b0;
            eop_done <= 1'b0;
            rr_ptr   <= (out_sel == SELW'(NUM_REQS - 1)) ? '0 : out_sel + SELW'(1);
          end else begin
            eop_sent <= sent_now;
            eop_done <= done_now;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Progress watchdog: saturating counter, sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog      <= '0;
      stall_err <= 1'b0;
    end else if (TIMEOUT == 0) begin
      wdog <= '0;
    end else if ((state != STREAM) || out_fire || commit_fire || release_now) begin
      wdog <= '0;
    end else if (wdog >= WDW'(TIMEOUT - 1)) begin
      stall_err <= 1'b1;
    end else begin
      wdog <= wdog + WDW'(1);
    end
  end

endmodule

// File: tb/tb_vx_reduce_arbiter.sv
// Self-checking bench for vx_reduce_arbiter: queue-based port sources, round-robin grant model.
module tb_vx_reduce_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_sop, req_eop, req_ready, req_ready_z;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_sop, out_eop, out_ready;
  logic            out_valid_z, out_sop_z, out_eop_z;
  logic [DW-1:0]   out_data, out_data_z;
  logic [1:0]      out_sel, out_sel_z;
  logic            commit_fire, commit_eop, busy, busy_z, stall_err, stall_err_z;

  always #5 clk = ~clk;

  vx_reduce_arbiter #(.NUM_REQS(N), .DATAW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_sop(req_sop),
    .req_eop(req_eop), .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready), .out_sel(out_sel),
    .commit_fire(commit_fire), .commit_eop(commit_eop), .busy(busy), .stall_err(stall_err));

  vx_reduce_arbiter #(.NUM_REQS(N), .DATAW(DW), .TIMEOUT(0)) dut_nowd (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_sop(req_sop),
    .req_eop(req_eop), .req_ready(req_ready_z), .out_valid(out_valid_z), .out_data(out_data_z),
    .out_sop(out_sop_z), .out_eop(out_eop_z), .out_ready(out_ready), .out_sel(out_sel_z),
    .commit_fire(commit_fire), .commit_eop(commit_eop), .busy(busy_z), .stall_err(stall_err_z));

  typedef struct {logic [DW-1:0] d; bit sop; bit eop;} pkt_t;

  pkt_t q[N][$];
  int   grant_log[$];
  int   checks, failures, fire_cnt, owner, commit_delay;
  bit   wait_commit, auto_commit, rand_ready;

  function automatic bit any_pending();
    bit r = 1'b0;
    for (int p = 0; p < N; p++) if (q[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      req_valid[p] = (q[p].size() > 0);
      if (q[p].size() > 0) begin
        req_data[p*DW +: DW] = q[p][0].d;
        req_sop[p] = q[p][0].sop;
        req_eop[p] = q[p][0].eop;
      end else begin
        req_data[p*DW +: DW] = '0;
        req_sop[p] = 1'b0;
        req_eop[p] = 1'b0;
      end
    end
  endtask

  task automatic add_seq(input int p, input int len);
    for (int i = 0; i < len; i++) begin
      pkt_t k;
      k.d = {$urandom, $urandom};
      k.sop = (i == 0);
      k.eop = (i == len - 1);
      q[p].push_back(k);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int p = 0; p < N; p++) q[p].delete();
    grant_log.delete();
    commit_fire = 1'b0; commit_eop = 1'b0; out_ready = 1'b0;
    wait_commit = 1'b0; auto_commit = 1'b0; rand_ready = 1'b0;
    fire_cnt = 0; owner = -1; commit_delay = 0;
    drive();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    #1;
  endtask

  // One clock: check the settled cycle, take the edge, retire accepted packets, drive the next cycle.
  task automatic tick();
    logic [N-1:0] fired;
    #1;
    fired = req_valid & req_ready;
    checks++;
    if ($countones(req_ready) > 1) begin
      failures++; $display("FAIL ready_onehot: req_ready=%b required one-hot or zero", req_ready);
    end
    if (wait_commit) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL leak_after_eop: out_valid=%b required 0", out_valid);
      end
    end
    if (out_valid && out_ready) begin
      checks++;
      if (out_data !== q[out_sel][0].d || out_sop !== q[out_sel][0].sop || out_eop !== q[out_sel][0].eop) begin
        failures++;
        $display("FAIL fwd_data: port=%0d data=%h sop=%b eop=%b required data=%h sop=%b eop=%b",
                 out_sel, out_data, out_sop, out_eop, q[out_sel][0].d, q[out_sel][0].sop, q[out_sel][0].eop);
      end
      checks++;
      if (out_sop ? (owner != -1) : (int'(out_sel) != owner)) begin
        failures++; $display("FAIL interleave: fire from port %0d sop=%b while owner=%0d", out_sel, out_sop, owner);
      end
      owner = out_eop ? -1 : int'(out_sel);
      fire_cnt++;
      if (out_sop) grant_log.push_back(int'(out_sel));
      if (out_eop && auto_commit) begin wait_commit = 1'b1; commit_delay = $urandom_range(1, 3); end
    end
    @(posedge clk); #1;
    commit_fire = 1'b0; commit_eop = 1'b0;
    for (int p = 0; p < N; p++) if (fired[p]) void'(q[p].pop_front());
    if (wait_commit) begin
      commit_delay--;
      if (commit_delay == 0) begin commit_fire = 1'b1; commit_eop = 1'b1; wait_commit = 1'b0; end
    end else if (auto_commit && $urandom_range(0, 4) == 0) begin
      commit_fire = 1'b1; commit_eop = 1'b0;
    end
    if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
    drive();
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((any_pending() || busy || wait_commit) && n < budget) begin tick(); n++; end
    checks++;
    if (n >= budget) begin failures++; $display("FAIL drain_timeout: cycles=%0d required < %0d", n, budget); end
  endtask

  task automatic check_grants(input string name, input int exp[$]);
    checks++;
    if (grant_log.size() != exp.size()) begin
      failures++; $display("FAIL %s_count: grants=%0d required %0d", name, grant_log.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (grant_log[i] != exp[i]) begin
          failures++; $display("FAIL %s_order: grant[%0d]=%0d required %0d", name, i, grant_log[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: %b required 0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: %b required 0", out_valid); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: %b required 0000", req_ready); end
    checks++; if (out_sel !== 2'd0) begin failures++; $display("FAIL reset_out_sel: %0d required 0", out_sel); end
    checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL reset_stall_err: %b required 0", stall_err); end
  endtask

  task automatic test_single_port();
    do_reset();
    add_seq(2, 3); out_ready = 1'b1; drive(); #1;
    checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL bubble: out_valid=%b req_ready=%b required 0/0000", out_valid, req_ready); end
    tick();
    checks++; if (out_sel !== 2'd2 || busy !== 1'b1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL grant_p2: sel=%0d busy=%b valid=%b required 2/1/1", out_sel, busy, out_valid); end
    repeat (3) tick();
    checks++; if (fire_cnt != 3 || out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL three_fires: fires=%0d valid=%b busy=%b required 3/0/1", fire_cnt, out_valid, busy); end
    repeat (2) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_until_commit: busy=%b required 1", busy); end
    commit_fire = 1'b1; commit_eop = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL release_on_commit: busy=%b required 0", busy); end
    add_seq(1, 1); add_seq(3, 1); drive(); #1;
    tick();
    checks++; if (out_sel !== 2'd3) begin failures++; $display("FAIL rr_ptr_after_p2: sel=%0d required 3", out_sel); end
  endtask

  task automatic test_two_ports();
    int exp[$] = '{0, 3};
    do_reset();
    auto_commit = 1'b1; rand_ready = 1'b1;
    add_seq(0, 3); add_seq(3, 3); drive(); #1;
    run_until_idle(200);
    check_grants("two_ports", exp);
  endtask

  task automatic test_commit_first();
    do_reset();
    add_seq(1, 1); out_ready = 1'b0; drive(); #1;
    tick();
    commit_fire = 1'b1; commit_eop = 1'b1;
    tick(); tick();
    out_ready = 1'b1; #1;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL early_commit_hold: busy=%b valid=%b required 1/1", busy, out_valid); end
    tick();
    checks++; if (busy !== 1'b0 || fire_cnt != 1) begin
      failures++; $display("FAIL early_commit_release: busy=%b fires=%0d required 0/1", busy, fire_cnt); end
    add_seq(2, 1); out_ready = 1'b0; drive(); #1;
    tick();
    checks++; if (out_sel !== 2'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL grant_after_early: sel=%0d busy=%b required 2/1", out_sel, busy); end
    out_ready = 1'b1; commit_fire = 1'b1; commit_eop = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || fire_cnt != 2) begin
      failures++; $display("FAIL same_cycle_release: busy=%b fires=%0d required 0/2", busy, fire_cnt); end
  endtask

  task automatic test_round_robin();
    int exp[$] = '{0, 1, 2, 3, 0};
    do_reset();
    auto_commit = 1'b1; out_ready = 1'b1;
    add_seq(0, 1); add_seq(0, 1); add_seq(1, 1); add_seq(2, 1); add_seq(3, 1);
    drive(); #1;
    run_until_idle(200);
    check_grants("round_robin", exp);
  endtask

  task automatic test_watchdog();
    do_reset();
    add_seq(0, 2); out_ready = 1'b0; drive(); #1;
    tick();
    repeat (7) tick();
    checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL wdog_early: stall_err=%b required 0", stall_err); end
    tick();
    checks++; if (stall_err !== 1'b1) begin failures++; $display("FAIL wdog_fire: stall_err=%b required 1", stall_err); end
    checks++; if (stall_err_z !== 1'b0) begin failures++; $display("FAIL wdog_disabled: stall_err=%b required 0", stall_err_z); end
    auto_commit = 1'b1; out_ready = 1'b1;
    run_until_idle(100);
    checks++; if (stall_err !== 1'b1 || stall_err_z !== 1'b0) begin
      failures++; $display("FAIL wdog_sticky: stall_err=%b/%b required 1/0", stall_err, stall_err_z); end
  endtask

  task automatic test_async_reset();
    do_reset();
    add_seq(1, 1); out_ready = 1'b1; auto_commit = 1'b1; drive(); #1;
    run_until_idle(50);
    auto_commit = 1'b0;
    add_seq(3, 1); drive(); #1;
    tick(); tick();
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL pre_reset_state: busy=%b valid=%b required 1/0", busy, out_valid); end
    #1; reset = 1'b0; #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 4'b0000 || out_sel !== 2'd0) begin
      failures++; $display("FAIL async_reset: busy=%b valid=%b ready=%b sel=%0d required 0/0/0000/0",
                           busy, out_valid, req_ready, out_sel); end
    for (int p = 0; p < N; p++) q[p].delete();
    owner = -1; drive();
    @(posedge clk); #1; reset = 1'b1;
    add_seq(0, 1); add_seq(2, 1); drive(); #1;
    tick();
    checks++; if (out_sel !== 2'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL post_reset_rr: sel=%0d busy=%b required 0/1", out_sel, busy); end
    auto_commit = 1'b1;
    run_until_idle(100);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int cnt[N];
      int exp[$];
      int ptr = 0;
      int left = 0;
      do_reset();
      auto_commit = 1'b1; rand_ready = 1'b1; out_ready = 1'b1;
      for (int p = 0; p < N; p++) begin
        cnt[p] = $urandom_range(0, 3);
        left += cnt[p];
        for (int s = 0; s < cnt[p]; s++) add_seq(p, $urandom_range(1, 3));
      end
      while (left > 0) begin
        for (int k = 0; k < N; k++) begin
          int p = (ptr + k) % N;
          if (cnt[p] > 0) begin exp.push_back(p); cnt[p]--; left--; ptr = (p + 1) % N; break; end
        end
      end
      drive(); #1;
      run_until_idle(2000);
      check_grants("random", exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; out_ready = 1'b0; commit_fire = 1'b0; commit_eop = 1'b0;
    req_valid = '0; req_data = '0; req_sop = '0; req_eop = '0;
    test_reset();
    test_single_port();
    test_two_ports();
    test_commit_first();
    test_round_robin();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
